// File: rtl/mean_window_avg.sv
// Running average over the last 2^LOG_DEPTH accepted mean samples, with
// min/max peak-hold since the last reset or clear.
module mean_window_avg #(
  parameter int unsigned SIZE      = 32,
  parameter int unsigned LOG_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mean_valid,
  input  logic [SIZE-1:0]      mean_in,
  input  logic                 clear,
  output logic [SIZE-1:0]      avg_out,
  output logic                 avg_valid,
  output logic [SIZE-1:0]      min_out,
  output logic [SIZE-1:0]      max_out,
  output logic [LOG_DEPTH:0]   fill_count,
  output logic                 full
);

  localparam int unsigned DEPTH = 1 << LOG_DEPTH;
  localparam int unsigned SW    = SIZE + LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] FULL_CNT = DEPTH[LOG_DEPTH:0];

  logic [SIZE-1:0]      win_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [SW-1:0]        sum_q, sum_d;
  logic [LOG_DEPTH:0]   fill_q, fill_d;
  logic [SIZE-1:0]      min_q, min_d, max_q, max_d;
  logic [SIZE-1:0]      avg_q, avg_d;
  logic                 avg_valid_q, avg_valid_d;
  logic                 pend_q, pend_d;
  logic                 flush, accept, is_full;
  logic [SIZE-1:0]      old;

  assign flush   = reset | clear;
  assign accept  = mean_valid & ~flush;
  assign is_full = (fill_q == FULL_CNT);
  // Entries are never reset, so the oldest value only counts once the window is full.
  assign old     = is_full ? win_q[wr_ptr_q] : '0;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    sum_d       = sum_q;
    fill_d      = fill_q;
    min_d       = min_q;
    max_d       = max_q;
    pend_d      = 1'b0;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      sum_d    = '0;
      fill_d   = '0;
      min_d    = '1;
      max_d    = '0;
      avg_d    = '0;
    end else begin
      // Second stage: publish the sum registered by the previous accept.
      if (pend_q) begin
        avg_d       = sum_q[SW-1:LOG_DEPTH];
        avg_valid_d = 1'b1;
      end
      if (accept) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        sum_d    = sum_q + SW'(mean_in) - SW'(old);
        fill_d   = is_full ? fill_q : fill_q + 1'b1;
        min_d    = (mean_in < min_q) ? mean_in : min_q;
        max_d    = (mean_in > max_q) ? mean_in : max_q;
        pend_d   = (fill_d == FULL_CNT);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      sum_q       <= '0;
      fill_q      <= '0;
      min_q       <= '1;
      max_q       <= '0;
      pend_q      <= 1'b0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      sum_q       <= sum_d;
      fill_q      <= fill_d;
      min_q       <= min_d;
      max_q       <= max_d;
      pend_q      <= pend_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) win_q[wr_ptr_q] <= mean_in;
  end

  assign avg_out    = avg_q;
  assign avg_valid  = avg_valid_q;
  assign min_out    = min_q;
  assign max_out    = max_q;
  assign fill_count = fill_q;
  assign full       = is_full;

endmodule

// File: tb/tb_mean_window_avg.sv
// Directed bench for mean_window_avg (SIZE=32, LOG_DEPTH=2) with hand-computed expectations.
module tb_mean_window_avg;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        mean_valid = 1'b0;
  logic [31:0] mean_in = '0;
  logic [31:0] avg_out, min_out, max_out;
  logic        avg_valid, full;
  logic [2:0]  fill_count;

  int errors = 0;
  int checks = 0;

  mean_window_avg #(.SIZE(32), .LOG_DEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .mean_valid (mean_valid),
    .mean_in    (mean_in),
    .clear      (clear),
    .avg_out    (avg_out),
    .avg_valid  (avg_valid),
    .min_out    (min_out),
    .max_out    (max_out),
    .fill_count (fill_count),
    .full       (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Apply inputs for one cycle; outputs are sampled 1ns after the edge.
  task automatic drive(input logic r, input logic c, input logic v, input logic [31:0] d);
    reset = r; clear = c; mean_valid = v; mean_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic [31:0] d);
    drive(1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, '0);
    check("rst_avg",   avg_out, 32'd0);
    check("rst_valid", 32'(avg_valid), 32'd0);
    check("rst_min",   min_out, 32'hFFFF_FFFF);
    check("rst_max",   max_out, 32'd0);
    check("rst_fill",  32'(fill_count), 32'd0);
    check("rst_full",  32'(full), 32'd0);

    // Fill 1,2,3,4
    for (int i = 1; i <= 4; i++) begin
      acc(32'(i));
      check("fill_cnt",   32'(fill_count), 32'(i));
      check("fill_valid", 32'(avg_valid), 32'd0);
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_min",  min_out, 32'd1);
    check("fill_max",  max_out, 32'd4);
    idle();
    check("avg1_valid", 32'(avg_valid), 32'd1);
    check("avg1_val",   avg_out, 32'd2);
    idle();
    check("idle_valid", 32'(avg_valid), 32'd0);
    check("idle_hold",  avg_out, 32'd2);

    acc(32'd8);
    check("acc8_valid", 32'(avg_valid), 32'd0);
    idle();
    check("avg8_valid", 32'(avg_valid), 32'd1);
    check("avg8_val",   avg_out, 32'd4);

    // 5 x9 with idle between accepts
    for (int i = 0; i < 9; i++) begin
      acc(32'd5);
      check("tog_acc_valid", 32'(avg_valid), 32'd0);
      idle();
      check("tog_valid", 32'(avg_valid), 32'd1);
      check("tog_avg",   avg_out, 32'd5);
      check("tog_fill",  32'(fill_count), 32'd4);
    end

    // All-ones saturation of the window
    for (int i = 0; i < 6; i++) begin
      acc(32'hFFFF_FFFF);
      if (i == 1) begin
        check("ff_mix_valid", 32'(avg_valid), 32'd1);
        check("ff_mix_avg",   avg_out, 32'h4000_0003);
      end
    end
    idle();
    check("ff_valid", 32'(avg_valid), 32'd1);
    check("ff_avg",   avg_out, 32'hFFFF_FFFF);
    check("ff_max",   max_out, 32'hFFFF_FFFF);
    check("ff_min",   min_out, 32'd1);

    // Clear with a sample present and an average pending
    acc(32'd9);
    drive(1'b0, 1'b1, 1'b1, 32'd7);
    check("clr_valid", 32'(avg_valid), 32'd0);
    check("clr_avg",   avg_out, 32'd0);
    check("clr_fill",  32'(fill_count), 32'd0);
    check("clr_full",  32'(full), 32'd0);
    check("clr_min",   min_out, 32'hFFFF_FFFF);
    check("clr_max",   max_out, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      acc(32'(10 * i));
      check("clr_fill_cnt", 32'(fill_count), 32'(i));
      check("clr_no_valid", 32'(avg_valid), 32'd0);
    end
    idle();
    check("clr_avg_valid", 32'(avg_valid), 32'd1);
    check("clr_avg_val",   avg_out, 32'd25);
    check("clr_min2",      min_out, 32'd10);
    check("clr_max2",      max_out, 32'd40);

    // Reset mid-fill, then refill with 4s
    drive(1'b0, 1'b1, 1'b0, '0);
    acc(32'd100);
    acc(32'd200);
    check("mid_fill", 32'(fill_count), 32'd2);
    drive(1'b1, 1'b0, 1'b0, '0);
    check("mid_rst_fill", 32'(fill_count), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      acc(32'd4);
      check("mid_valid", 32'(avg_valid), 32'd0);
    end
    idle();
    check("mid_avg_valid", 32'(avg_valid), 32'd1);
    check("mid_avg",       avg_out, 32'd4);

    // Long reset with valid asserted, then accept on the deassert edge
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b1, 32'd55);
    check("lrst_fill", 32'(fill_count), 32'd0);
    check("lrst_max",  max_out, 32'd0);
    acc(32'd77);
    check("post_fill", 32'(fill_count), 32'd1);
    check("post_min",  min_out, 32'd77);
    check("post_max",  max_out, 32'd77);
    check("post_valid", 32'(avg_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
